// File: rtl/bram_sdp_reader.sv
// Burst reader for a 36-bit simple-dual-port BRAM read port: issues credit-limited
// reads, buffers returning words in a small FIFO and presents them as a valid/ready stream.
module bram_sdp_reader #(
    parameter int ADDR_W     = 9,
    parameter int DOA_REG    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              rden,
    output logic              regce,
    input  logic [35:0]       rddata,
    output logic [35:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int LAT   = 1 + DOA_REG;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              final_rd;

    // vld_pipe[k] marks a read issued k cycles ago; last_pipe tags the burst's final read
    logic [LAT:1]      vld_pipe;
    logic [LAT:1]      last_pipe;
    logic [CNT_W:0]    outstanding;
    logic              credit_ok;

    logic [35:0]       mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              push, pop;

    always_comb begin
        outstanding = '0;
        for (int i = 1; i <= LAT; i++)
            outstanding = outstanding + {{CNT_W{1'b0}}, vld_pipe[i]};
    end

    // Reads in flight plus buffered words can never exceed the FIFO capacity
    assign credit_ok = (outstanding + {1'b0, fifo_cnt}) < DEPTH_C;
    assign rden      = (state == ISSUE) && credit_ok;
    assign final_rd  = rden && (remaining == {{ADDR_W{1'b0}}, 1'b1});
    assign rdaddr    = addr;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    generate
        if (DOA_REG != 0) begin : g_regce
            assign regce = vld_pipe[1];
        end else begin : g_noregce
            assign regce = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (count == '0) ? DONE : ISSUE;
            ISSUE: if (final_rd) state_nx = DRAIN;
            DRAIN: if (pop && m_last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (state == IDLE && start && count != '0) begin
            addr      <= base_addr;
            remaining <= count;
        end else if (rden) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[1]  <= rden;
            last_pipe[1] <= final_rd;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign push = vld_pipe[LAT];
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rddata;
            mem_last[wr_ptr] <= last_pipe[LAT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head is gated so the stream reads zero whenever nothing is buffered
    assign m_valid = (fifo_cnt != '0);
    assign m_data  = m_valid ? mem_data[rd_ptr] : 36'h0;
    assign m_last  = m_valid && mem_last[rd_ptr];

endmodule

// File: tb/tb_bram_sdp_reader.sv
// Directed bench for bram_sdp_reader: one instance per output-register setting,
// each driven from a behavioural BRAM whose word encodes its address.
module tb_bram_sdp_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start0 = 0, ready0 = 1;
    logic [8:0]  base0 = '0;
    logic [9:0]  cnt0 = '0;
    logic [8:0]  rdaddr0;
    logic        rden0, regce0, m_valid0, m_last0, busy0, done0;
    logic [35:0] rddata0 = '0, m_data0;

    logic        start1 = 0, ready1 = 1;
    logic [8:0]  base1 = '0;
    logic [9:0]  cnt1 = '0;
    logic [8:0]  rdaddr1;
    logic        rden1, regce1, m_valid1, m_last1, busy1, done1;
    logic [35:0] rddata1 = '0, q1 = '0, m_data1;

    int vectors = 0;
    int miscompares = 0;
    int issued, got;

    always #5 clk = ~clk;

    bram_sdp_reader #(.ADDR_W(9), .DOA_REG(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base0), .count(cnt0),
        .rdaddr(rdaddr0), .rden(rden0), .regce(regce0), .rddata(rddata0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(ready0), .m_last(m_last0),
        .busy(busy0), .done(done0));

    bram_sdp_reader #(.ADDR_W(9), .DOA_REG(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1), .count(cnt1),
        .rdaddr(rdaddr1), .rden(rden1), .regce(regce1), .rddata(rddata1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(ready1), .m_last(m_last1),
        .busy(busy1), .done(done1));

    function automatic logic [35:0] word(input logic [8:0] a);
        return {a, 18'h3C3C3, a};
    endfunction

    always @(posedge clk) if (rden0) rddata0 <= word(rdaddr0);

    always @(posedge clk) begin
        if (rden1)  q1 <= word(rdaddr1);
        if (regce1) rddata1 <= q1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect0(input string tag, input bit rd, input logic [8:0] ad, input bit mv,
                           input logic [35:0] d, input bit lst, input bit dn, input bit bz);
        chk({tag, ".rden"}, 64'(rden0), 64'(rd));
        if (rd) chk({tag, ".rdaddr"}, 64'(rdaddr0), 64'(ad));
        chk({tag, ".m_valid"}, 64'(m_valid0), 64'(mv));
        if (mv) chk({tag, ".m_data"}, 64'(m_data0), 64'(d));
        chk({tag, ".m_last"}, 64'(m_last0), 64'(lst));
        chk({tag, ".done"}, 64'(done0), 64'(dn));
        chk({tag, ".busy"}, 64'(busy0), 64'(bz));
    endtask

    // Runs dut0 until n words are taken, checking issued addresses and delivered words
    task automatic collect0(input string tag, input logic [8:0] base, input int n, input bit rnd);
        logic [8:0] ea;
        for (int c = 0; c < 1200 && got < n; c++) begin
            if (rden0) begin
                ea = base + 9'(issued);
                chk({tag, ".rdaddr"}, 64'(rdaddr0), 64'(ea));
                issued++;
            end
            if (m_valid0 && ready0) begin
                ea = base + 9'(got);
                chk({tag, ".m_data"}, 64'(m_data0), 64'(word(ea)));
                chk({tag, ".m_last"}, 64'(m_last0), 64'(got == n - 1));
                got++;
            end
            tick();
            if (rnd) ready0 = 1'($urandom_range(0, 1));
        end
        chk({tag, ".words"}, 64'(got), 64'(n));
        chk({tag, ".reads"}, 64'(issued), 64'(n));
        chk({tag, ".done"}, 64'(done0), 64'(1));
        ready0 = 1;
        tick();
        chk({tag, ".idle"}, 64'(busy0), 64'(0));
    endtask

    task automatic burst0(input string tag, input logic [8:0] base, input int n, input bit rnd);
        start0 = 1; base0 = base; cnt0 = 10'(n);
        tick();
        start0 = 0;
        issued = 0; got = 0;
        collect0(tag, base, n, rnd);
    endtask

    initial begin
        int  nrd;
        logic prev_rden;

        // Reset state
        #2 rst_n = 0;
        #1;
        expect0("rst", 0, 9'h0, 0, 36'h0, 0, 0, 0);
        chk("rst.rdaddr", 64'(rdaddr0), 64'(0));
        chk("rst.m_data", 64'(m_data0), 64'(0));
        chk("rst.regce", 64'(regce0), 64'(0));
        chk("rst.regce1", 64'(regce1), 64'(0));
        chk("rst.m_valid1", 64'(m_valid1), 64'(0));
        tick(); tick();
        rst_n = 1;
        tick();
        expect0("rel", 0, 9'h0, 0, 36'h0, 0, 0, 0);

        // Basic 4-word burst at full throughput, exact cycle timing
        start0 = 1; base0 = 9'h010; cnt0 = 10'd4;
        tick(); start0 = 0;
        expect0("t1c1", 1, 9'h010, 0, 36'h0, 0, 0, 1);
        tick(); expect0("t1c2", 1, 9'h011, 0, 36'h0, 0, 0, 1);
        tick(); expect0("t1c3", 1, 9'h012, 1, word(9'h010), 0, 0, 1);
        tick(); expect0("t1c4", 1, 9'h013, 1, word(9'h011), 0, 0, 1);
        tick(); expect0("t1c5", 0, 9'h0, 1, word(9'h012), 0, 0, 1);
        tick(); expect0("t1c6", 0, 9'h0, 1, word(9'h013), 1, 0, 1);
        tick(); expect0("t1c7", 0, 9'h0, 0, 36'h0, 0, 1, 1);
        tick(); expect0("t1c8", 0, 9'h0, 0, 36'h0, 0, 0, 0);
        chk("t1.regce", 64'(regce0), 64'(0));

        // Address wrap at the top of the array
        burst0("wrap", 9'h1FE, 4, 0);

        // Zero-length request, plus a start during DONE that must be ignored
        start0 = 1; base0 = 9'h050; cnt0 = 10'd0;
        tick();
        start0 = 1; cnt0 = 10'd4;
        expect0("z.c1", 0, 9'h0, 0, 36'h0, 0, 1, 1);
        tick(); start0 = 0;
        expect0("z.c2", 0, 9'h0, 0, 36'h0, 0, 0, 0);
        tick();
        expect0("z.c3", 0, 9'h0, 0, 36'h0, 0, 0, 0);

        // Back-pressure: reads stop once the credits are used up
        ready0 = 0;
        start0 = 1; base0 = 9'h020; cnt0 = 10'd16;
        tick(); start0 = 0;
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            if (rden0) nrd++;
            tick();
        end
        chk("bp.reads", 64'(nrd), 64'(4));
        chk("bp.m_valid", 64'(m_valid0), 64'(1));
        chk("bp.m_data", 64'(m_data0), 64'(word(9'h020)));
        chk("bp.rdaddr", 64'(rdaddr0), 64'(9'h024));
        ready0 = 1;
        issued = 4; got = 0;
        collect0("bp", 9'h020, 16, 0);

        // Random back-pressure, then a full-array burst that wraps to base
        burst0("rnd", 9'h0F0, 9, 1);
        burst0("full", 9'h005, 512, 0);

        // Output register variant with random m_ready
        start1 = 1; base1 = 9'h100; cnt1 = 10'd3;
        tick(); start1 = 0;
        prev_rden = 0; got = 0; issued = 0;
        for (int c = 0; c < 100 && !done1; c++) begin
            chk("d1.regce", 64'(regce1), 64'(prev_rden));
            prev_rden = rden1;
            if (rden1) begin
                chk("d1.rdaddr", 64'(rdaddr1), 64'(9'h100 + 9'(issued)));
                issued++;
            end
            if (m_valid1 && ready1) begin
                chk("d1.m_data", 64'(m_data1), 64'(word(9'h100 + 9'(got))));
                chk("d1.m_last", 64'(m_last1), 64'(got == 2));
                got++;
            end
            tick();
            ready1 = 1'($urandom_range(0, 1));
        end
        chk("d1.words", 64'(got), 64'(3));
        chk("d1.reads", 64'(issued), 64'(3));
        chk("d1.done", 64'(done1), 64'(1));
        ready1 = 1;

        // Reset in the middle of a 10-word burst
        ready0 = 1;
        start0 = 1; base0 = 9'h040; cnt0 = 10'd10;
        tick(); start0 = 0;
        got = 0;
        for (int c = 0; c < 50 && got < 4; c++) begin
            if (m_valid0) got++;
            tick();
        end
        chk("mr.pre_words", 64'(got), 64'(4));
        chk("mr.pre_busy", 64'(busy0), 64'(1));
        rst_n = 0;
        #1;
        expect0("mr.rst", 0, 9'h0, 0, 36'h0, 0, 0, 0);
        chk("mr.rdaddr", 64'(rdaddr0), 64'(0));
        chk("mr.m_data", 64'(m_data0), 64'(0));
        tick(); tick();
        rst_n = 1;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_valid0 || rden0 || busy0) nrd++;
        end
        chk("mr.quiet", 64'(nrd), 64'(0));
        burst0("mr.next", 9'h080, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
